add64_rr_sched: RTL and testbench

Round-robin scheduler and sequencer for a shared 64-bit carry-select add datapath. It arbitrates between two requesters with valid/ready handshakes and captures the winner's operands. It then evaluates the sum over four cycles, one 16-bit carry-select slice per cycle with the carry rippled through a register, and returns the result on a valid/ready response port. It sits between the operand-issue logic and the result consumers, replacing per-requester 64-bit adders.

---
 rtl/add64_sched_pkg.sv | 21 ++
 rtl/csa_slice16.sv | 34 +++
 rtl/add64_rr_sched.sv | 128 ++++++++++++
 tb/tb_add64_rr_sched.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add64_sched_pkg.sv
// Shared types and constants for the round-robin scheduled 64-bit slice adder.
package add64_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 64;
  localparam int SLICE     = 16;
  localparam int NSLICE    = DEF_WIDTH / SLICE;

  // A single-slice configuration still needs a 1-bit counter.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W = cnt_bits(NSLICE);

endpackage

// File: rtl/csa_slice16.sv
// Combinational carry-select slice: two ripple chains (carry-in 0 and 1),
// with the real incoming carry choosing between them at the output.
module csa_slice16
  import add64_sched_pkg::*;
#(
  parameter int W = SLICE
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] sum0, sum1;
  logic         c0, c1;

  always_comb begin
    sum0 = '0;
    sum1 = '0;
    c0   = 1'b0;
    c1   = 1'b1;
    for (int i = 0; i < W; i++) begin
      sum0[i] = a[i] ^ b[i] ^ c0;
      c0      = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
      sum1[i] = a[i] ^ b[i] ^ c1;
      c1      = (a[i] & b[i]) | (c1 & (a[i] ^ b[i]));
    end
  end

  assign sum  = cin ? sum1 : sum0;
  assign cout = cin ? c1 : c0;

endmodule

// File: rtl/add64_rr_sched.sv
// Two-requester round-robin front end sharing one carry-select slice that
// evaluates a WIDTH-bit sum over WIDTH/SLICE cycles.
module add64_rr_sched
  import add64_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy
);

  localparam int                  NUM_SLICES = WIDTH / SLICE;
  localparam int                  CNT_BITS   = cnt_bits(NUM_SLICES);
  localparam logic [CNT_BITS-1:0] LAST_CNT   = CNT_BITS'(NUM_SLICES - 1);

  state_t              state, state_next;
  logic                ptr;
  logic [CNT_BITS-1:0] cnt;
  logic [WIDTH-1:0]    op_a, op_b, sum_reg;
  logic                carry, id_reg, cout_reg;

  logic                pref_valid, other_valid;
  logic                grant_valid, grant_id;
  logic                last_slice;
  logic [SLICE-1:0]    slice_a, slice_b, slice_sum;
  logic                slice_cout;

  // The pointer names the preferred requester; the other only wins when it is alone.
  assign pref_valid  = ptr ? req1_valid : req0_valid;
  assign other_valid = ptr ? req0_valid : req1_valid;
  assign grant_valid = pref_valid | other_valid;
  assign grant_id    = pref_valid ? ptr : ~ptr;
  assign last_slice  = (cnt == LAST_CNT);

  assign slice_a = op_a[int'(cnt)*SLICE +: SLICE];
  assign slice_b = op_b[int'(cnt)*SLICE +: SLICE];

  csa_slice16 #(
    .W(SLICE)
  ) u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry),
    .sum (slice_sum),
    .cout(slice_cout)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = CALC;
      CALC:    if (last_slice)  state_next = DONE;
      DONE:    if (rsp_ready)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Readies are gated by reset so nothing looks accepted while reset is held.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset && state == IDLE && grant_valid) begin
      req0_ready = ~grant_id;
      req1_ready = grant_id;
    end
    rsp_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr      <= 1'b0;
      cnt      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      sum_reg  <= '0;
      id_reg   <= 1'b0;
      cout_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            id_reg <= grant_id;
            ptr    <= ~grant_id;
            op_a   <= grant_id ? req1_a   : req0_a;
            op_b   <= grant_id ? req1_b   : req0_b;
            carry  <= grant_id ? req1_cin : req0_cin;
            cnt    <= '0;
          end
        end
        CALC: begin
          sum_reg[int'(cnt)*SLICE +: SLICE] <= slice_sum;
          carry <= slice_cout;
          cnt   <= cnt + 1'b1;
          if (last_slice) cout_reg <= slice_cout;
        end
        default: ;
      endcase
    end
  end

  assign rsp_id   = id_reg;
  assign rsp_sum  = sum_reg;
  assign rsp_cout = cout_reg;

endmodule

// File: tb/tb_add64_rr_sched.sv
// Self-checking bench for add64_rr_sched: directed scenarios plus a randomized
// run against a transaction-level arbitration/addition model.
module tb_add64_rr_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_cin = 1'b0, req1_cin = 1'b0;
  logic        rsp_valid, rsp_id, rsp_cout, busy;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_sum;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        id;
    logic [64:0] res;
  } exp_t;

  always #5 clock = ~clock;

  add64_rr_sched #(.WIDTH(64)) dut (
    .clock     (clock),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_cin  (req0_cin),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_cin  (req1_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + 65'(cin);
  endfunction

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0:       v = '1;
      1:       v = '0;
      2:       v = 64'h0000_FFFF_0000_FFFF;
      3:       v = 64'h7FFF_FFFF_FFFF_FFFF;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Called on a negedge; returns the number of rising edges until rsp_valid.
  task automatic wait_rsp(output int edges);
    edges = 0;
    while (rsp_valid !== 1'b1 && edges < 50) begin
      @(posedge clock);
      @(negedge clock);
      edges++;
    end
  endtask

  task automatic test_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    n_cmp++; if (req0_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_req0_ready: got %b want 0", req0_ready); end
    n_cmp++; if (req1_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_req1_ready: got %b want 0", req1_ready); end
    n_cmp++; if (rsp_valid !== 1'b0)  begin n_fail++; $display("[TB] FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_id !== 1'b0)     begin n_fail++; $display("[TB] FAIL rst_rsp_id: got %b want 0", rsp_id); end
    n_cmp++; if (rsp_sum !== 64'h0)   begin n_fail++; $display("[TB] FAIL rst_rsp_sum: got %h want 0", rsp_sum); end
    n_cmp++; if (rsp_cout !== 1'b0)   begin n_fail++; $display("[TB] FAIL rst_rsp_cout: got %b want 0", rsp_cout); end
    n_cmp++; if (busy !== 1'b0)       begin n_fail++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    @(negedge clock);
    reset      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_slice_boundary();
    int edges;
    @(negedge clock);
    req0_a = 64'h0000_0000_0000_FFFF; req0_b = 64'h1; req0_cin = 1'b0;
    req0_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++; $display("[TB] FAIL slice_accept: readies %b want 01", {req1_ready, req0_ready}); end
    @(posedge clock);
    @(negedge clock);
    req0_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL slice_busy: got %b want 1", busy); end
    wait_rsp(edges);
    n_cmp++; if (edges != 4) begin n_fail++; $display("[TB] FAIL slice_latency: got %0d edges want 4", edges); end
    n_cmp++; if (rsp_sum !== 64'h0000_0000_0001_0000) begin n_fail++; $display("[TB] FAIL slice_sum: got %h want 0000000000010000", rsp_sum); end
    n_cmp++; if (rsp_cout !== 1'b0) begin n_fail++; $display("[TB] FAIL slice_cout: got %b want 0", rsp_cout); end
    n_cmp++; if (rsp_id !== 1'b0) begin n_fail++; $display("[TB] FAIL slice_id: got %b want 0", rsp_id); end
    @(posedge clock);
    @(negedge clock);
    #1;
    n_cmp++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL slice_release: valid/busy %b want 00", {rsp_valid, busy}); end
  endtask

  task automatic test_full_wrap();
    int edges;
    @(negedge clock);
    req1_a = 64'hFFFF_FFFF_FFFF_FFFF; req1_b = 64'h0; req1_cin = 1'b1;
    req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b10) begin n_fail++; $display("[TB] FAIL wrap_accept: readies %b want 10", {req1_ready, req0_ready}); end
    @(posedge clock);
    @(negedge clock);
    req1_valid = 1'b0;
    wait_rsp(edges);
    n_cmp++; if (edges != 4) begin n_fail++; $display("[TB] FAIL wrap_latency: got %0d edges want 4", edges); end
    n_cmp++; if ({rsp_id, rsp_cout, rsp_sum} !== {1'b1, 1'b1, 64'h0}) begin
      n_fail++; $display("[TB] FAIL wrap_result: got id=%b cout=%b sum=%h want id=1 cout=1 sum=0", rsp_id, rsp_cout, rsp_sum);
    end
    @(posedge clock);
  endtask

  task automatic test_alternation();
    exp_t q[$];
    int   acc_ids[$];
    int   acc_cyc[$];
    int   cyc = 0, n_rsp = 0, issued = 2;
    logic refresh0 = 1'b1, refresh1 = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    rsp_ready = 1'b1;
    while (n_rsp < 6 && cyc < 100) begin
      @(negedge clock);
      if (refresh0) begin
        if (acc_ids.size() == 0 || issued < 6) begin
          req0_a = rnd64(); req0_b = rnd64(); req0_cin = 1'($urandom_range(0, 1)); req0_valid = 1'b1;
          if (acc_ids.size() != 0) issued++;
        end else req0_valid = 1'b0;
        refresh0 = 1'b0;
      end
      if (refresh1) begin
        if (acc_ids.size() == 0 || issued < 6) begin
          req1_a = rnd64(); req1_b = rnd64(); req1_cin = 1'($urandom_range(0, 1)); req1_valid = 1'b1;
          if (acc_ids.size() != 0) issued++;
        end else req1_valid = 1'b0;
        refresh1 = 1'b0;
      end
      #1;
      if (req0_valid && req0_ready) begin
        acc_ids.push_back(0); acc_cyc.push_back(cyc);
        q.push_back('{1'b0, ref_add(req0_a, req0_b, req0_cin)});
        refresh0 = 1'b1;
      end else if (req1_valid && req1_ready) begin
        acc_ids.push_back(1); acc_cyc.push_back(cyc);
        q.push_back('{1'b1, ref_add(req1_a, req1_b, req1_cin)});
        refresh1 = 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
        n_cmp++;
        if (q.size() == 0 || {rsp_id, rsp_cout, rsp_sum} !== q[0]) begin
          n_fail++; $display("[TB] FAIL alt_result: got id=%b cout=%b sum=%h queued=%0d", rsp_id, rsp_cout, rsp_sum, q.size());
        end
        if (q.size() != 0) void'(q.pop_front());
        n_rsp++;
      end
      cyc++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n_cmp++; if (acc_ids.size() != 6) begin n_fail++; $display("[TB] FAIL alt_count: got %0d acceptances want 6", acc_ids.size()); end
    for (int k = 0; k < acc_ids.size(); k++) begin
      n_cmp++; if (acc_ids[k] != k % 2) begin n_fail++; $display("[TB] FAIL alt_order[%0d]: got id %0d want %0d", k, acc_ids[k], k % 2); end
      if (k > 0) begin
        n_cmp++;
        if (acc_cyc[k] - acc_cyc[k-1] != 6) begin n_fail++; $display("[TB] FAIL alt_spacing[%0d]: got %0d cycles want 6", k, acc_cyc[k] - acc_cyc[k-1]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int          edges;
    logic [64:0] exp0, exp1;
    @(negedge clock);
    req0_a = rnd64(); req0_b = rnd64(); req0_cin = 1'b1; req0_valid = 1'b1;
    req1_valid = 1'b0; rsp_ready = 1'b0;
    exp0 = ref_add(req0_a, req0_b, req0_cin);
    #1;
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++; $display("[TB] FAIL bp_accept: readies %b want 01", {req1_ready, req0_ready}); end
    @(posedge clock);
    @(negedge clock);
    req0_valid = 1'b0;
    req1_a = rnd64(); req1_b = rnd64(); req1_cin = 1'b0; req1_valid = 1'b1;
    exp1 = ref_add(req1_a, req1_b, req1_cin);
    wait_rsp(edges);
    n_cmp++; if (edges != 4) begin n_fail++; $display("[TB] FAIL bp_latency: got %0d edges want 4", edges); end
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin @(posedge clock); @(negedge clock); end
      #1;
      n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_valid[%0d]: got %b want 1", k, rsp_valid); end
      n_cmp++; if ({rsp_id, rsp_cout, rsp_sum} !== {1'b0, exp0}) begin
        n_fail++; $display("[TB] FAIL bp_hold[%0d]: got id=%b %b_%h want id=0 %h", k, rsp_id, rsp_cout, rsp_sum, exp0);
      end
      n_cmp++; if ({req1_ready, req0_ready} !== 2'b00) begin n_fail++; $display("[TB] FAIL bp_ready[%0d]: got %b want 00", k, {req1_ready, req0_ready}); end
    end
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_release_valid: got %b want 1", rsp_valid); end
    @(posedge clock);
    @(negedge clock);
    #1;
    n_cmp++; if ({rsp_valid, req1_ready, req0_ready} !== 3'b010) begin
      n_fail++; $display("[TB] FAIL bp_after_release: valid/r1/r0 %b want 010", {rsp_valid, req1_ready, req0_ready});
    end
    @(posedge clock);
    @(negedge clock);
    req1_valid = 1'b0;
    wait_rsp(edges);
    n_cmp++; if ({rsp_id, rsp_cout, rsp_sum} !== {1'b1, exp1}) begin
      n_fail++; $display("[TB] FAIL bp_second: got id=%b %b_%h want id=1 %h", rsp_id, rsp_cout, rsp_sum, exp1);
    end
    @(posedge clock);
  endtask

  task automatic test_reset_mid();
    int          edges;
    logic [64:0] exp1;
    @(negedge clock);
    req0_a = rnd64(); req0_b = rnd64(); req0_cin = 1'b0; req0_valid = 1'b1;
    req1_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req0_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clock);
      #1;
      n_cmp++; if ({busy, rsp_valid, req1_ready, req0_ready} !== 4'b0000) begin
        n_fail++; $display("[TB] FAIL midrst_outputs[%0d]: busy/valid/r1/r0 %b want 0000", k, {busy, rsp_valid, req1_ready, req0_ready});
      end
    end
    @(negedge clock);
    reset = 1'b0;
    req0_a = 64'h7FFF_FFFF_FFFF_FFFF; req0_b = 64'h0; req0_cin = 1'b1;
    req1_a = rnd64(); req1_b = rnd64(); req1_cin = 1'b1;
    exp1 = ref_add(req1_a, req1_b, req1_cin);
    #1;
    n_cmp++; if ({rsp_valid, req1_ready, req0_ready} !== 3'b001) begin
      n_fail++; $display("[TB] FAIL midrst_priority: valid/r1/r0 %b want 001", {rsp_valid, req1_ready, req0_ready});
    end
    @(posedge clock);
    @(negedge clock);
    req0_valid = 1'b0;
    wait_rsp(edges);
    n_cmp++; if (edges != 4) begin n_fail++; $display("[TB] FAIL midrst_latency: got %0d edges want 4", edges); end
    n_cmp++; if ({rsp_id, rsp_cout, rsp_sum} !== {1'b0, 1'b0, 64'h8000_0000_0000_0000}) begin
      n_fail++; $display("[TB] FAIL midrst_result: got id=%b cout=%b sum=%h want id=0 cout=0 sum=8000000000000000", rsp_id, rsp_cout, rsp_sum);
    end
    @(posedge clock);
    @(negedge clock);
    #1;
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b10) begin n_fail++; $display("[TB] FAIL midrst_next_grant: got %b want 10", {req1_ready, req0_ready}); end
    @(posedge clock);
    @(negedge clock);
    req1_valid = 1'b0;
    wait_rsp(edges);
    n_cmp++; if ({rsp_id, rsp_cout, rsp_sum} !== {1'b1, exp1}) begin
      n_fail++; $display("[TB] FAIL midrst_second: got id=%b %b_%h want id=1 %h", rsp_id, rsp_cout, rsp_sum, exp1);
    end
    @(posedge clock);
  endtask

  task automatic test_random();
    localparam int N      = 3000;
    localparam int BUDGET = 60000;
    exp_t        q[$];
    logic        pend[2];
    logic [63:0] ra[2], rb[2];
    logic        rc[2];
    int          issued = 0, n_acc = 0, n_rsp = 0, cyc = 0, age = 0;
    logic        ptr_m = 1'b0, outstanding = 1'b0;
    logic        winner, acc, fire, exp_valid;
    logic [1:0]  vld, exp_rdy;
    pend[0] = 1'b0; pend[1] = 1'b0;
    @(negedge clock);
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    while (n_rsp < N && cyc < BUDGET) begin
      @(negedge clock);
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && issued < N && $urandom_range(0, 2) != 0) begin
          pend[r] = 1'b1; ra[r] = rnd64(); rb[r] = rnd64(); rc[r] = 1'($urandom_range(0, 1));
          issued++;
        end
      end
      req0_valid = pend[0]; req0_a = ra[0]; req0_b = rb[0]; req0_cin = rc[0];
      req1_valid = pend[1]; req1_a = ra[1]; req1_b = rb[1]; req1_cin = rc[1];
      rsp_ready  = ($urandom_range(0, 3) != 0);
      #1;
      vld     = {pend[1], pend[0]};
      exp_rdy = 2'b00;
      acc     = 1'b0;
      winner  = ptr_m;
      if (!outstanding && vld != 2'b00) begin
        winner  = vld[ptr_m] ? ptr_m : ~ptr_m;
        exp_rdy = winner ? 2'b10 : 2'b01;
        acc     = 1'b1;
      end
      exp_valid = outstanding && age >= 4;
      fire      = exp_valid && rsp_ready;
      n_cmp++; if ({req1_ready, req0_ready} !== exp_rdy) begin
        n_fail++; $display("[TB] FAIL rnd_ready@%0d: got %b want %b", cyc, {req1_ready, req0_ready}, exp_rdy);
      end
      n_cmp++; if (rsp_valid !== exp_valid) begin
        n_fail++; $display("[TB] FAIL rnd_valid@%0d: got %b want %b", cyc, rsp_valid, exp_valid);
      end
      if (fire) begin
        n_cmp++;
        if (q.size() == 0 || {rsp_id, rsp_cout, rsp_sum} !== q[0]) begin
          n_fail++; $display("[TB] FAIL rnd_result@%0d: got id=%b %b_%h want %h", cyc, rsp_id, rsp_cout, rsp_sum, (q.size() != 0) ? q[0] : '0);
        end
        if (q.size() != 0) void'(q.pop_front());
        n_rsp++;
      end
      @(posedge clock);
      if (acc) begin
        q.push_back('{winner, ref_add(ra[winner], rb[winner], rc[winner])});
        pend[winner] = 1'b0;
        ptr_m        = ~winner;
        outstanding  = 1'b1;
        age          = 0;
        n_acc++;
      end else if (fire) begin
        outstanding = 1'b0;
      end else if (outstanding) begin
        age++;
      end
      cyc++;
    end
    @(negedge clock);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n_cmp++; if (cyc >= BUDGET) begin n_fail++; $display("[TB] FAIL rnd_timeout: ran %0d cycles, limit %0d", cyc, BUDGET); end
    n_cmp++; if (n_acc != N) begin n_fail++; $display("[TB] FAIL rnd_accepted: got %0d want %0d", n_acc, N); end
    n_cmp++; if (n_rsp != N) begin n_fail++; $display("[TB] FAIL rnd_responses: got %0d want %0d", n_rsp, N); end
    n_cmp++; if (q.size() != 0) begin n_fail++; $display("[TB] FAIL rnd_leftover: got %0d pending want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_slice_boundary();
    test_full_wrap();
    test_alternation();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
